interleaver_seq: RTL

// Sequenced, clash-free interleaver address generator for one sparse junction.

---
 rtl/interleaver_seq.sv | 103 ++++++++++
 1 files changed

// File: rtl/interleaver_seq.sv
// Sequenced clash-free interleaver address generator: walks C = D*fo cycles per pass,
// emitting one bank-local index per lane, with optional seed/stride rotation and valid/ready.
module interleaver_seq #(
  parameter  int p  = 64,
  parameter  int fo = 8,
  parameter  int z  = 8,
  localparam int D  = p / z,
  localparam int LD = (p == z) ? 1 : $clog2(p / z),
  localparam int LC = (p * fo == z) ? 1 : $clog2(p * fo / z),
  localparam int LP = $clog2(p)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            mode,
  input  logic [LD-1:0]   seed,
  input  logic [LD-1:0]   stride,
  input  logic            ready,
  output logic            busy,
  output logic            valid,
  output logic            last,
  output logic [LC-1:0]   cycle_index,
  output logic [z*LP-1:0] memory_index
);

  localparam int C     = D * fo;
  localparam int LOG_D = $clog2(D);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [LC-1:0] r_c;
  logic          r_mode;
  logic [LD-1:0] r_seed;
  logic [LD-1:0] r_stride;

  logic          w_run;
  logic          w_accept;
  logic          w_final;
  logic [LC-1:0] w_sweep;
  logic [LD-1:0] w_base;
  logic [LD-1:0] w_lane_a [z];

  assign w_run    = (r_state == S_RUN);
  assign w_accept = w_run && ready;
  assign w_final  = (r_c == LC'(C - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_accept && w_final) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Pass configuration is captured only on an accepted start, so a mid-pass start is inert.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_c      <= '0;
      r_mode   <= 1'b0;
      r_seed   <= '0;
      r_stride <= '0;
    end else if (!w_run && start) begin
      r_c      <= '0;
      r_mode   <= mode;
      r_seed   <= seed;
      r_stride <= stride;
    end else if (w_accept) begin
      r_c <= w_final ? '0 : r_c + 1'b1;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    w_sweep = r_c >> LOG_D;
    w_base  = LD'(r_c) + LD'(LD'(w_sweep) * r_stride) + r_seed;
    for (int i = 0; i < z; i++) begin
      w_lane_a[i] = r_mode ? w_base + LD'(i) : LD'(r_c);
      if (D == 1) w_lane_a[i] = '0;
    end
  end

  // Lane i only ever addresses bank i, so a beat can never clash on a bank.
  always_comb begin
    busy         = w_run;
    valid        = w_run;
    last         = w_run && w_final;
    cycle_index  = r_c;
    memory_index = '0;
    for (int i = 0; i < z; i++) begin
      if (w_run) memory_index[i*LP +: LP] = LP'(i * D) + LP'(w_lane_a[i]);
    end
  end

endmodule
